// File: rtl/seq_booth_mul.sv
// rtl/seq_booth_mul.sv - iterative signed radix-4 Booth multiplier, one digit per clock
module seq_booth_mul #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 approx_en,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    function automatic logic [PW-1:0] low_mask();
        logic [PW-1:0] m;
        for (int k = 0; k < PW; k++) begin
            m[k] = (k < APPROX_BITS);
        end
        return m;
    endfunction

    localparam logic [PW-1:0] LOW_MASK = low_mask();

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic            prev_q, prev_d;
    logic            approx_q, approx_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            dig_zero, dig_dbl, dig_neg;
    logic [PW-1:0]   mag, pp, pp_m;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prev_q   <= 1'b0;
            approx_q <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prev_q   <= prev_d;
            approx_q <= approx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Current Booth digit from the low multiplier pair plus the bit shifted out last.
    always_comb begin
        dig_zero = 1'b0;
        dig_dbl  = 1'b0;
        dig_neg  = 1'b0;
        case ({mplier_q[1:0], prev_q})
            3'b000, 3'b111: dig_zero = 1'b1;
            3'b011:         dig_dbl  = 1'b1;
            3'b100: begin
                dig_dbl = 1'b1;
                dig_neg = 1'b1;
            end
            3'b101, 3'b110: dig_neg  = 1'b1;
            default:        dig_zero = 1'b0;
        endcase
        mag  = dig_dbl ? {mcand_q[PW-2:0], 1'b0} : mcand_q;
        pp   = dig_zero ? '0 : (dig_neg ? (~mag + PW'(1)) : mag);
        pp_m = approx_q ? (pp & ~LOW_MASK) : pp;
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prev_d   = prev_q;
        approx_d = approx_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (state_q)
            IDLE, DONE: begin
                // The DONE cycle also accepts start so ops can issue every NDIG+1 cycles.
                state_d = IDLE;
                if (start) begin
                    mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
                    mplier_d = b;
                    prev_d   = 1'b0;
                    approx_d = approx_en;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_q + pp_m;
                mcand_d  = {mcand_q[PW-3:0], 2'b00};
                mplier_d = mplier_q >> 2;
                prev_d   = mplier_q[1];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    p_d     = acc_q + pp_m;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

// File: tb/tb_seq_booth_mul.sv
// tb/tb_seq_booth_mul.sv - self-checking bench for seq_booth_mul against an arithmetic reference
module tb_seq_booth_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        approx_en = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy0, done0, busy1, done1;
    logic [15:0] p0, p1;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    seq_booth_mul #(.WIDTH(8), .APPROX_BITS(4)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .approx_en(approx_en),
        .busy(busy0), .done(done0), .p(p0)
    );

    seq_booth_mul #(.WIDTH(8), .APPROX_BITS(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .approx_en(approx_en),
        .busy(busy1), .done(done1), .p(p1)
    );

    // Exact: plain product. Approx: sum of Booth partial products, each with low bits cleared.
    function automatic logic [15:0] ref_p(input int av, input int bv, input bit ap, input int abits);
        longint acc = 0;
        longint pp;
        longint mask;
        int hi, mid, lo;
        if (!ap) return 16'(av * bv);
        mask = (longint'(1) << abits) - 1;
        for (int i = 0; i < 4; i++) begin
            hi  = (bv >> (2*i+1)) & 1;
            mid = (bv >> (2*i)) & 1;
            lo  = (i == 0) ? 0 : ((bv >> (2*i-1)) & 1);
            pp  = longint'(-2*hi + mid + lo) * longint'(av) * (longint'(1) << (2*i));
            acc += pp & ~mask;
        end
        return acc[15:0];
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after a clock edge with the DUT idle or in its done cycle.
    task automatic op(input logic [7:0] av, input logic [7:0] bv, input bit ap, output int lat);
        a = av; b = bv; approx_en = ap; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); approx_en = 1'($urandom);
        lat = 0;
        while (done0 !== 1'b1 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_chk(input string tag, input logic [7:0] av, input logic [7:0] bv, input bit ap);
        int lat;
        op(av, bv, ap, lat);
        chk({tag, " latency"}, 16'(lat), 16'd4);
        chk({tag, " p4"}, p0, ref_p(int'($signed(av)), int'($signed(bv)), ap, 4));
        chk({tag, " p0"}, p1, ref_p(int'($signed(av)), int'($signed(bv)), ap, 0));
    endtask

    task automatic dir(input string tag, input int av, input int bv, input bit ap,
                       input int e4, input int e0);
        int lat;
        op(8'(av), 8'(bv), ap, lat);
        chk({tag, " latency"}, 16'(lat), 16'd4);
        chk({tag, " p4"}, p0, 16'(e4));
        chk({tag, " p0"}, p1, 16'(e0));
    endtask

    initial begin
        int dones;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset busy", {15'b0, busy0}, 16'd0);
        chk("reset done", {15'b0, done0}, 16'd0);
        chk("reset p", p0, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        dir("m16xm16",   -16,  -16, 1'b0,   256,    256);
        dir("m107x32",  -107,   32, 1'b0, -3424,  -3424);
        dir("m128xm128",-128, -128, 1'b0, 16384,  16384);
        dir("m128x127", -128,  127, 1'b0, -16256, -16256);
        dir("7x0",         7,    0, 1'b0,     0,      0);
        dir("1x1",         1,    1, 1'b0,     1,      1);
        dir("ap60x5",     60,    5, 1'b1,   288,    300);
        dir("ap1x1",       1,    1, 1'b1,     0,      1);
        dir("apm128xm128",-128,-128,1'b1, 16384,  16384);

        // start held high: second op accepted in the done cycle, p held between completions
        @(posedge clk); #1;
        chk("idle busy", {15'b0, busy0}, 16'd0);
        a = 8'd25; b = 8'(-3); approx_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        chk("run busy", {15'b0, busy0}, 16'd1);
        dones = 0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            if (done0 === 1'b1) dones++;
            if (n == 4) begin
                chk("hs done1", {15'b0, done0}, 16'd1);
                chk("hs p1", p0, 16'(-75));
                a = 8'(-9); b = 8'd11;
            end
            if (n == 6) begin
                a = 8'd100; b = 8'd100;
                chk("hs p stable", p0, 16'(-75));
            end
            if (n == 8) chk("hs p stable2", p0, 16'(-75));
            if (n == 9) begin
                chk("hs done2", {15'b0, done0}, 16'd1);
                chk("hs p2", p0, 16'(-99));
                start = 1'b0;
            end
        end
        chk("hs done count", 16'(dones), 16'd2);
        @(posedge clk); #1;
        chk("hs back idle", {15'b0, busy0}, 16'd0);

        // asynchronous reset in the second RUN cycle
        a = 8'd50; b = 8'd50; approx_en = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst busy", {15'b0, busy0}, 16'd0);
        chk("rst done", {15'b0, done0}, 16'd0);
        chk("rst p", p0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        run_chk("post rst", 8'(-77), 8'd93, 1'b0);

        for (int i = 0; i < 10000; i++) begin
            run_chk("rand", 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
